// File: rtl/spi_sclk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_sclk_ctrl
// Purpose  : SPI master transfer sequencer. Generates chip select, SCLK with
//            selectable CPOL/CPHA from a programmable half-period divider,
//            and one-cycle SHIFT/SAMPLE strobes for the shift register.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sclk_ctrl #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [DIV_W-1:0] DIV,
    input  logic [CNT_W-1:0] NBITS,
    input  logic             CPOL,
    input  logic             CPHA,
    output logic             BUSY,
    output logic             DONE,
    output logic             CS_N,
    output logic             SCLK,
    output logic             SHIFT,
    output logic             SAMPLE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [DIV_W-1:0]   r_hcnt,  w_hcnt_nxt;
    logic [CNT_W:0]     r_ecnt,  w_ecnt_nxt;   // one extra bit so 2^CNT_W bits never wrap
    logic [DIV_W-1:0]   r_div,   w_div_nxt;
    logic [CNT_W-1:0]   r_nbits, w_nbits_nxt;
    logic               r_cpol,  w_cpol_nxt;
    logic               r_cpha,  w_cpha_nxt;
    logic               r_busy,  w_busy_nxt;
    logic               r_done,  w_done_nxt;
    logic               r_cs_n,  w_cs_n_nxt;
    logic               r_sclk,  w_sclk_nxt;
    logic               r_shift, w_shift_nxt;
    logic               r_sample, w_sample_nxt;

    logic               w_hend;    // half period elapsed
    logic               w_lead;    // upcoming toggle is a leading edge
    logic               w_last;    // upcoming toggle is the final trailing edge

    assign w_hend = (r_hcnt == r_div);
    // Toggle numbers are 1-based; ecnt holds toggles already done, so an even
    // count means the next toggle is odd, i.e. a leading edge.
    assign w_lead = ~r_ecnt[0];
    assign w_last = (r_ecnt == {r_nbits, 1'b1});

    // State and output registers; reset aborts any transfer without DONE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= S_IDLE;
            r_hcnt   <= '0;
            r_ecnt   <= '0;
            r_div    <= '0;
            r_nbits  <= '0;
            r_cpol   <= 1'b0;
            r_cpha   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cs_n   <= 1'b1;
            r_sclk   <= 1'b0;
            r_shift  <= 1'b0;
            r_sample <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_hcnt   <= w_hcnt_nxt;
            r_ecnt   <= w_ecnt_nxt;
            r_div    <= w_div_nxt;
            r_nbits  <= w_nbits_nxt;
            r_cpol   <= w_cpol_nxt;
            r_cpha   <= w_cpha_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_cs_n   <= w_cs_n_nxt;
            r_sclk   <= w_sclk_nxt;
            r_shift  <= w_shift_nxt;
            r_sample <= w_sample_nxt;
        end
    end

    // Next-state and next-output logic; strobes and DONE default low.
    always_comb begin
        w_state_nxt  = r_state;
        w_hcnt_nxt   = r_hcnt;
        w_ecnt_nxt   = r_ecnt;
        w_div_nxt    = r_div;
        w_nbits_nxt  = r_nbits;
        w_cpol_nxt   = r_cpol;
        w_cpha_nxt   = r_cpha;
        w_busy_nxt   = r_busy;
        w_cs_n_nxt   = r_cs_n;
        w_sclk_nxt   = r_sclk;
        w_done_nxt   = 1'b0;
        w_shift_nxt  = 1'b0;
        w_sample_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_sclk_nxt = CPOL;
                if (START) begin
                    w_div_nxt   = DIV;
                    w_nbits_nxt = NBITS;
                    w_cpol_nxt  = CPOL;
                    w_cpha_nxt  = CPHA;
                    w_cs_n_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_hcnt_nxt  = '0;
                    w_ecnt_nxt  = '0;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_hend) begin
                    w_hcnt_nxt  = '0;
                    w_state_nxt = S_RUN;
                end else begin
                    w_hcnt_nxt  = r_hcnt + DIV_W'(1);
                end
            end
            S_RUN: begin
                if (w_hend) begin
                    w_hcnt_nxt = '0;
                    w_sclk_nxt = ~r_sclk;
                    w_ecnt_nxt = r_ecnt + (CNT_W+1)'(1);
                    if (r_cpha) begin
                        w_shift_nxt  = w_lead;
                        w_sample_nxt = ~w_lead;
                    end else begin
                        w_sample_nxt = w_lead;
                        w_shift_nxt  = ~w_lead & ~w_last;
                    end
                    if (w_last) begin
                        w_state_nxt = S_HOLD;
                    end
                end else begin
                    w_hcnt_nxt = r_hcnt + DIV_W'(1);
                end
            end
            S_HOLD: begin
                if (w_hend) begin
                    w_hcnt_nxt  = '0;
                    w_ecnt_nxt  = '0;
                    w_cs_n_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_hcnt_nxt  = r_hcnt + DIV_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign BUSY   = r_busy;
    assign DONE   = r_done;
    assign CS_N   = r_cs_n;
    assign SCLK   = r_sclk;
    assign SHIFT  = r_shift;
    assign SAMPLE = r_sample;

endmodule
`default_nettype wire

// File: tb/tb_spi_sclk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_sclk_ctrl
// Purpose  : Directed self-checking bench for spi_sclk_ctrl. Edge numbers
//            count CLK rising edges from the one that accepts START (edge 0);
//            outputs are sampled 1 ns after each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_sclk_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic [7:0] DIV = '0;
    logic [4:0] NBITS = '0;
    logic       CPOL = 1'b0;
    logic       CPHA = 1'b0;
    logic       BUSY, DONE, CS_N, SCLK, SHIFT, SAMPLE;

    int n_chk = 0;
    int n_bad = 0;

    // Per-transfer statistics filled in by run_xfer
    int cs_at0, busy_at0, idle_sclk;
    int n_tog, n_rise, n_fall, first_tog, last_tog, min_gap, max_gap;
    int n_samp, samp_first, samp_last, samp_lead;
    int n_shft, shft_first, shft_last, shft_lead, n_both;
    int n_done, done_edge, cs_at_done, busy_at_done, sclk_at_done, wave_err;

    spi_sclk_ctrl #(.DIV_W(8), .CNT_W(5)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .START  (START),
        .DIV    (DIV),
        .NBITS  (NBITS),
        .CPOL   (CPOL),
        .CPHA   (CPHA),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .CS_N   (CS_N),
        .SCLK   (SCLK),
        .SHIFT  (SHIFT),
        .SAMPLE (SAMPLE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // SCLK level after edge e: toggle k lands on edge p*(k+1), 2(n+1) toggles.
    function automatic int exp_sclk(input int e, input int p, input int n, input int cpol);
        int t;
        if (e < 2 * p) return cpol;
        t = e / p - 1;
        if (t > 2 * (n + 1)) t = 2 * (n + 1);
        return cpol ^ (t & 1);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One transfer with START pulsed at edge 0. restart_at pulses START again
    // at that edge; chg_at forces DIV to 0 from that edge on.
    task automatic run_xfer(input int div, input int nb, input int cpol, input int cpha,
                            input int restart_at, input int chg_at, input int limit);
        int e;
        int prev;
        DIV   = 8'(div);
        NBITS = 5'(nb);
        CPOL  = 1'(cpol);
        CPHA  = 1'(cpha);
        START = 1'b0;
        tick();
        idle_sclk = int'(SCLK);
        START = 1'b1;
        tick();
        START = 1'b0;
        e = 0;
        cs_at0 = int'(CS_N);  busy_at0 = int'(BUSY);
        prev = int'(SCLK);
        n_tog = 0; n_rise = 0; n_fall = 0; first_tog = -1; last_tog = -1;
        min_gap = 1 << 30; max_gap = 0;
        n_samp = 0; samp_first = -1; samp_last = -1; samp_lead = 0;
        n_shft = 0; shft_first = -1; shft_last = -1; shft_lead = 0; n_both = 0;
        n_done = 0; done_edge = -1; cs_at_done = -1; busy_at_done = -1; sclk_at_done = -1;
        wave_err = 0;
        while (e < limit) begin
            START = ((e + 1) == restart_at);
            if ((e + 1) == chg_at) DIV = 8'd0;
            tick();
            e++;
            if (int'(SCLK) != exp_sclk(e, div + 1, nb, cpol)) wave_err++;
            if (int'(SCLK) != prev) begin
                if (last_tog >= 0) begin
                    if (e - last_tog < min_gap) min_gap = e - last_tog;
                    if (e - last_tog > max_gap) max_gap = e - last_tog;
                end
                if (first_tog < 0) first_tog = e;
                last_tog = e;
                n_tog++;
                if (SCLK) n_rise++; else n_fall++;
                prev = int'(SCLK);
            end
            if (SAMPLE) begin
                n_samp++;
                if (samp_first < 0) samp_first = e;
                samp_last = e;
                if (int'(SCLK) != cpol) samp_lead++;
            end
            if (SHIFT) begin
                n_shft++;
                if (shft_first < 0) shft_first = e;
                shft_last = e;
                if (int'(SCLK) != cpol) shft_lead++;
            end
            if (SAMPLE && SHIFT) n_both++;
            if (DONE) begin
                n_done++;
                if (done_edge < 0) begin
                    done_edge = e; cs_at_done = int'(CS_N);
                    busy_at_done = int'(BUSY); sclk_at_done = int'(SCLK);
                end
            end
            if (done_edge >= 0 && e >= done_edge + 3) break;
        end
        START = 1'b0;
    endtask

    initial begin
        int dcount;
        // ---------------- reset state ----------------
        RST_N = 1'b0;
        repeat (3) tick();
        check("rst_busy",   BUSY,   0);
        check("rst_done",   DONE,   0);
        check("rst_cs_n",   CS_N,   1);
        check("rst_sclk",   SCLK,   0);
        check("rst_shift",  SHIFT,  0);
        check("rst_sample", SAMPLE, 0);
        RST_N = 1'b1;
        tick();

        // ---------------- CPOL=0 CPHA=0 DIV=1 NBITS=7 ----------------
        run_xfer(1, 7, 0, 0, -1, -1, 100);
        check("m0_cs_at0",     cs_at0, 0);
        check("m0_busy_at0",   busy_at0, 1);
        check("m0_rises",      n_rise, 8);
        check("m0_falls",      n_fall, 8);
        check("m0_first_tog",  first_tog, 4);
        check("m0_last_tog",   last_tog, 34);
        check("m0_wave",       wave_err, 0);
        check("m0_samples",    n_samp, 8);
        check("m0_samp_first", samp_first, 4);
        check("m0_samp_last",  samp_last, 32);
        check("m0_samp_lead",  samp_lead, 8);
        check("m0_shifts",     n_shft, 7);
        check("m0_shft_first", shft_first, 6);
        check("m0_shft_last",  shft_last, 30);
        check("m0_shft_lead",  shft_lead, 0);
        check("m0_both",       n_both, 0);
        check("m0_done_edge",  done_edge, 36);
        check("m0_done_cnt",   n_done, 1);
        check("m0_cs_done",    cs_at_done, 1);
        check("m0_busy_done",  busy_at_done, 0);

        // ---------------- CPOL=1 CPHA=1 ----------------
        run_xfer(1, 7, 1, 1, -1, -1, 100);
        check("m3_idle_sclk",  idle_sclk, 1);
        check("m3_first_tog",  first_tog, 4);
        check("m3_falls",      n_fall, 8);
        check("m3_last_tog",   last_tog, 34);
        check("m3_sclk_done",  sclk_at_done, 1);
        check("m3_wave",       wave_err, 0);
        check("m3_shifts",     n_shft, 8);
        check("m3_shft_lead",  shft_lead, 8);
        check("m3_samples",    n_samp, 8);
        check("m3_samp_lead",  samp_lead, 0);
        check("m3_both",       n_both, 0);
        check("m3_done_edge",  done_edge, 36);

        // ---------------- DIV=0 NBITS=0 ----------------
        run_xfer(0, 0, 0, 0, -1, -1, 50);
        check("d0_first_tog",  first_tog, 2);
        check("d0_last_tog",   last_tog, 3);
        check("d0_toggles",    n_tog, 2);
        check("d0_samples",    n_samp, 1);
        check("d0_shifts",     n_shft, 0);
        check("d0_done_edge",  done_edge, 4);

        // START held high: DONE at edge 4 ignored, re-accepted at edge 5
        DIV = 8'd0; NBITS = 5'd0; CPOL = 1'b0; CPHA = 1'b0;
        START = 1'b1;
        tick();                       // edge 0
        repeat (4) tick();            // edge 4
        check("hold_done_e4",  DONE, 1);
        check("hold_busy_e4",  BUSY, 0);
        check("hold_cs_e4",    CS_N, 1);
        tick();                       // edge 5
        check("hold_cs_e5",    CS_N, 0);
        check("hold_busy_e5",  BUSY, 1);
        START = 1'b0;
        dcount = 0;
        while (!DONE && dcount < 20) begin tick(); dcount++; end
        check("hold_2nd_done", DONE, 1);
        tick();

        // ---------------- restart ignored, DIV changed mid-transfer ----------------
        run_xfer(3, 3, 0, 0, 10, 12, 100);
        check("rs_done_edge",  done_edge, 40);
        check("rs_done_cnt",   n_done, 1);
        check("rs_toggles",    n_tog, 8);
        check("rs_min_gap",    min_gap, 4);
        check("rs_max_gap",    max_gap, 4);
        check("rs_wave",       wave_err, 0);
        check("rs_busy_end",   BUSY, 0);

        // ---------------- reset mid-transfer ----------------
        DIV = 8'd1; NBITS = 5'd7; CPOL = 1'b1; CPHA = 1'b0;
        tick();
        START = 1'b1;
        tick();                       // edge 0
        START = 1'b0;
        repeat (14) tick();           // edge 14
        check("ar_busy_pre",   BUSY, 1);
        @(posedge CLK);               // edge 15
        #1;
        RST_N = 1'b0;
        #1;
        check("ar_cs_n",       CS_N, 1);
        check("ar_sclk",       SCLK, 0);
        check("ar_busy",       BUSY, 0);
        check("ar_done",       DONE, 0);
        dcount = 0;
        repeat (3) begin tick(); if (DONE) dcount++; end
        RST_N = 1'b1;
        repeat (2) begin tick(); if (DONE) dcount++; end
        check("ar_no_done",    dcount, 0);
        run_xfer(1, 7, 0, 0, -1, -1, 100);
        check("ar_re_done",    done_edge, 36);
        check("ar_re_wave",    wave_err, 0);
        check("ar_re_samples", n_samp, 8);

        // ---------------- max length, max divider ----------------
        run_xfer(255, 31, 0, 0, -1, -1, 17000);
        check("mx_toggles",    n_tog, 64);
        check("mx_samples",    n_samp, 32);
        check("mx_shifts",     n_shft, 31);
        check("mx_wave",       wave_err, 0);
        check("mx_done_edge",  done_edge, 16896);
        check("mx_done_cnt",   n_done, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_sclk_ctrl.md
Name: spi_sclk_ctrl

Overview:
- Sequences one SPI master transfer on top of the programmable clock-divide scheme (count to an end value, toggle output, restart).
- Sits between the Wishbone register file (DIV, NBITS, CPOL, CPHA, START) and the shift register.
- Generates chip select, SCLK with the selected CPOL/CPHA, and single-cycle SHIFT/SAMPLE strobes for the shift register.
- Reports completion with BUSY/DONE.

Parameters:
- DIV_W, 8: width of the half-period divider value.
- CNT_W, 5: width of the bit-count field. Max transfer is 2^CNT_W bits.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  transfer request; sampled only in IDLE.
- DIV  in  DIV_W  SCLK half-period minus 1, in CLK cycles.
- NBITS  in  CNT_W  bits per transfer minus 1.
- CPOL  in  1  SCLK idle level.
- CPHA  in  1  0 = sample on leading edge; 1 = shift on leading edge.
- BUSY  out  1  high from START acceptance until DONE.
- DONE  out  1  one-cycle pulse when the transfer ends.
- CS_N  out  1  active-low chip select.
- SCLK  out  1  serial clock.
- SHIFT  out  1  one-cycle strobe: drive the next MOSI bit.
- SAMPLE  out  1  one-cycle strobe: capture MISO.

Behaviour:
- All outputs are registered.
- Reset values: BUSY=0, DONE=0, CS_N=1, SCLK=0, SHIFT=0, SAMPLE=0, state=IDLE, counters=0.
- Reset asserted mid-transfer aborts immediately to these values. No DONE is generated.
- Internal registers:
  - hcnt [DIV_W]: half-period counter.
  - ecnt [CNT_W+1]: SCLK edge counter.
  - Latched copies of DIV, NBITS, CPOL, CPHA, captured on START acceptance and held constant for the whole transfer.
- Timing reference: edge 0 is the CLK edge at which START is sampled high in IDLE.
- IDLE:
  - SCLK <= CPOL input every cycle.
  - START=1 latches the config; at edge 0 CS_N <= 0, BUSY <= 1, hcnt <= 0, go to SETUP.
- SETUP:
  - hcnt increments each cycle.
  - When hcnt == DIV: hcnt <= 0, go to RUN.
  - Transition occurs at edge DIV+1.
- RUN:
  - When hcnt == DIV: SCLK toggles, ecnt increments, hcnt <= 0. Otherwise hcnt increments.
  - Toggle k (k = 1..2(NBITS+1)) occurs at edge (DIV+1)(k+1).
  - Odd k is the leading edge; even k is the trailing edge.
  - After toggle 2(NBITS+1): go to HOLD, hcnt <= 0.
- Strobes (same edge as the SCLK toggle):
  - CPHA=0: SAMPLE on leading edges. SHIFT on trailing edges, except the final one.
  - CPHA=1: SHIFT on leading edges. SAMPLE on trailing edges.
  - Strobes are never both high in the same cycle.
- HOLD:
  - hcnt counts 0..DIV.
  - On hcnt == DIV: CS_N <= 1, BUSY <= 0, DONE <= 1 for one cycle, go to IDLE.
  - DONE edge = (DIV+1)(2·NBITS+4).
- START while BUSY=1, including the DONE cycle, is ignored. A new transfer can be accepted on the cycle after DONE.
- Changes to DIV/NBITS/CPOL/CPHA inputs during a transfer have no effect.
- Boundary cases:
  - DIV=0: SCLK = CLK/2.
  - NBITS=0: 1-bit transfer, 2 toggles.
  - NBITS=all-ones: 2^CNT_W bits. ecnt must not wrap, hence its CNT_W+1 width.
  - DIV=all-ones: counters must not wrap early.

Test Plan:
- Reset, CPOL=0, DIV=1, NBITS=7, CPHA=0, START pulse at edge 0:
  - CS_N low at edge 0.
  - SCLK rises at edges 4,8,…,32 and falls at 6,10,…,34.
  - 8 SAMPLE pulses (edges 4..32), 7 SHIFT pulses (edges 6..30).
  - DONE at edge 36, CS_N high at 36.
- Same with CPOL=1, CPHA=1:
  - SCLK idles high and falls first at edge 4.
  - 8 SHIFT pulses on leading edges, 8 SAMPLE pulses on trailing edges.
  - SCLK returns high at edge 34.
- DIV=0, NBITS=0:
  - Toggles at edges 2 and 3, DONE at edge 4.
  - START held high continuously: next transfer accepted at edge 5.
- START pulsed at edge 10 of a DIV=3, NBITS=3 transfer, with DIV changed to 0 mid-transfer:
  - Second START ignored.
  - Single DONE at edge 40; all toggles 4 cycles apart.
- RST_N driven low at edge 15 of a running transfer:
  - Outputs asynchronously at reset values (CS_N=1, SCLK=0, BUSY=0), no DONE.
  - After release, a fresh START gives a normal transfer.
- CNT_W=5, NBITS=31, DIV=255:
  - Exactly 64 toggles (32 SAMPLE, 31 SHIFT).
  - DONE at edge 256·66 = 16896.
